spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Receive-only SPI slave that deserialises 8-bit frames driven by the team's `spi_master` onto `spi_clk`/`spi_mosi`. Both SPI lines are oversampled by the system clock, so there is no second clock domain. Frame boundaries come from an idle timeout, because the link has no chip-select. Each completed byte is presented on a one-cycle valid strobe to downstream logic.

## Interface
Parameters:
- `CPOL`, 0: idle level of `spi_clk`. The sample edge is the transition away from `CPOL` (mode 0 / mode 2).
- `MSB_FIRST`, 0: 0 means the first received bit lands in `rx_data[0]`, matching `spi_master`. 1 means the first received bit lands in `rx_data[7]`.
- `MAIN_CLOCK_FREQ`, 27_000_000: `clk` frequency in Hz.
- `SPI_CLOCK_FREQ`, 10_000: nominal SPI bit rate in Hz.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchroniser. Minimum 2.
- `TIMEOUT_CYCLES`, 2*MAIN_CLOCK_FREQ/SPI_CLOCK_FREQ: number of `clk` cycles without an `spi_clk` edge that aborts a partial frame.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  SPI clock from the master. Asynchronous to `clk`.
- `spi_mosi`  in  1  SPI data from the master. Asynchronous to `clk`.
- `rx_data`  out  8  last complete byte. Held until the next complete byte.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new in that cycle.
- `rx_error`  out  1  one-cycle pulse; a partial frame was dropped on timeout.
- `busy`  out  1  high while a frame is partially received.

## Operation
- Synchroniser:
  - `spi_clk` and `spi_mosi` each pass through `SYNC_STAGES` flip-flops.
  - On reset, the clock chain is loaded with `CPOL` and the data chain with 0, so reset release never creates a spurious edge.
- Edge detect: one additional register on the synchronised clock.
  - `sample_edge` = the previous value equals `CPOL` and the current value equals `~CPOL`.
  - `any_edge` = the previous value differs from the current value.
- Data capture: on `sample_edge`, the synchronised `spi_mosi` bit is written into a shift register, at the position selected by `MSB_FIRST`.
- State machine, two states:
  - `IDLE`: `bit_cnt`=0 and `busy`=0. On `sample_edge`, capture bit 0, set `bit_cnt`=1, and move to `RECEIVE`.
  - `RECEIVE`: `busy`=1.
    - On each `sample_edge`, capture the bit and increment `bit_cnt`.
    - On the edge that completes bit 7, load `rx_data` with the assembled byte, pulse `rx_valid`, and return to `IDLE`.
- Timeout counter:
  - Counts only in `RECEIVE` and clears on every `any_edge`.
  - When it reaches `TIMEOUT_CYCLES`: discard the partial byte, pulse `rx_error`, and return to `IDLE`.
  - `rx_data` is left unchanged.
- Width rules:
  - `bit_cnt` is 3 bits.
  - The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates; it never wraps.
- Elaboration check: `MAIN_CLOCK_FREQ >= 8*SPI_CLOCK_FREQ` must hold, otherwise elaboration fails.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `rx_error`=0, `busy`=0.
  - State = `IDLE`, all counters 0.
- Latency: `rx_valid` rises `SYNC_STAGES`+2 `clk` edges after the 8th sample-edge transition is first captured at the `spi_clk` pin.
- `rx_valid` and `rx_error` are registered, each high for exactly 1 cycle, and never high together.
- Back-to-back frames:
  - The first edge of the next frame may come one SPI period after the last edge. No gap is required.
  - A `sample_edge` arriving in the same cycle as the completion is impossible at legal rates.
- Simultaneous events:
  - An `any_edge` and a timeout in the same cycle: the edge wins. The counter clears and no `rx_error` is raised.
  - 8th `sample_edge` together with a timeout: the byte completes and `rx_valid` pulses.
- Reset mid-frame: the partial byte is lost, no `rx_valid` or `rx_error` is raised, and the next `sample_edge` after release starts a new frame.
- No backpressure: a consumer that misses `rx_valid` loses the byte.

## Structure
- Shared package `spi_pkg`:
  - State encodings `IDLE`/`RECEIVE`.
  - `BITS_PER_FRAME`=8.
  - Reused by `spi_master`.
- One sub-module, `spi_input_sync`:
  - Contains the parametrised synchroniser, the edge-detect register and the `sample_edge`/`any_edge` outputs.
  - The same sub-module is reusable for a future MISO input on the master.

## Test plan
- 0xA5 sent by `spi_master` at 10 kHz, CPOL=0, LSB first -> exactly one `rx_valid`, `rx_data`=8'hA5, `busy` low afterwards.
- 0x3C then 0xC3 back-to-back -> two `rx_valid` pulses, with `rx_data`=8'h3C then 8'hC3, and no `rx_error`.
- 4 bits of 0xFF, then silence -> `rx_error` pulses `TIMEOUT_CYCLES` cycles after the last edge, `rx_data` stays at its old value, and a following 0x5A is received as 8'h5A.
- `rst` asserted for 3 cycles after bit 2 of 0x77, then a fresh 0x12 -> no pulse during reset, outputs at reset values, then `rx_valid` with 8'h12.
- CPOL=1 with 0x81, and separately MSB_FIRST=1 with the bit sequence 0,0,0,0,0,0,0,1 -> `rx_data`=8'h81 and 8'h01 respectively.
- Glitch-free reset release with `spi_clk` held at CPOL for 1000 cycles -> `rx_valid`, `rx_error` and `busy` all remain 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame size, FSM state encoding and bit placement helper.
// Used by both spi_slave_rx and spi_master.
package spi_pkg;

  localparam int BITS_PER_FRAME = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } spi_state_t;

  // Shift-register position of the bit with sequence number cnt.
  function automatic logic [2:0] bit_pos(input logic [2:0] cnt, input bit msb_first);
    return msb_first ? (3'(BITS_PER_FRAME - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Oversampling synchroniser for an SPI clock/data pair, with edge detection.
// Reset loads the clock chain with CPOL so that reset release never looks like an edge.
module spi_input_sync #(
  parameter bit CPOL        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_sdata,
  output logic o_data,
  output logic o_sample_edge,
  output logic o_any_edge
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   r_data;
  logic                   r_sample_edge;
  logic                   r_any_edge;
  logic                   w_clk_s;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];

  // Edge flags and data are registered together so the bit stays aligned with its edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync    <= {SYNC_STAGES{CPOL}};
      r_data_sync   <= '0;
      r_clk_prev    <= CPOL;
      r_data        <= 1'b0;
      r_sample_edge <= 1'b0;
      r_any_edge    <= 1'b0;
    end else begin
      r_clk_sync    <= {r_clk_sync[SYNC_STAGES-2:0], i_sclk};
      r_data_sync   <= {r_data_sync[SYNC_STAGES-2:0], i_sdata};
      r_clk_prev    <= w_clk_s;
      r_data        <= r_data_sync[SYNC_STAGES-1];
      r_sample_edge <= (r_clk_prev == CPOL) && (w_clk_s != CPOL);
      r_any_edge    <= (r_clk_prev != w_clk_s);
    end
  end

  assign o_data        = r_data;
  assign o_sample_edge = r_sample_edge;
  assign o_any_edge    = r_any_edge;

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave: oversampled spi_clk/spi_mosi, 8-bit frames, idle-timeout framing.
//  state   | meaning
//  IDLE    | no frame in progress, waiting for the first sample edge
//  RECEIVE | frame partially received, idle timeout armed
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter bit CPOL            = 1'b0,
  parameter bit MSB_FIRST       = 1'b0,
  parameter int MAIN_CLOCK_FREQ = 27_000_000,
  parameter int SPI_CLOCK_FREQ  = 10_000,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 2 * MAIN_CLOCK_FREQ / SPI_CLOCK_FREQ
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_clk,
  input  logic       i_spi_mosi,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_error,
  output logic       o_busy
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  if (MAIN_CLOCK_FREQ < 8 * SPI_CLOCK_FREQ) begin : g_bad_freq
    $error("spi_slave_rx: MAIN_CLOCK_FREQ must be at least 8x SPI_CLOCK_FREQ");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_slave_rx: SYNC_STAGES must be at least 2");
  end

  spi_state_t    r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid, r_rx_error;
  logic          w_valid_nxt, w_error_nxt;
  logic          w_data, w_sample_edge, w_any_edge, w_timeout;
  logic [2:0]    w_idx;

  spi_input_sync #(
    .CPOL        (CPOL),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sclk        (i_spi_clk),
    .i_sdata       (i_spi_mosi),
    .o_data        (w_data),
    .o_sample_edge (w_sample_edge),
    .o_any_edge    (w_any_edge)
  );

  // A coincident edge always beats the timeout.
  assign w_timeout = (r_state == RECEIVE) && (r_tmo_cnt == TMO_MAX) && !w_any_edge;
  assign w_idx     = bit_pos(r_bit_cnt, MSB_FIRST);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_valid_nxt   = 1'b0;
    w_error_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_cnt_nxt = 3'd0;
        if (w_sample_edge) begin
          w_shift_nxt[w_idx] = w_data;
          w_bit_cnt_nxt      = 3'd1;
          w_state_nxt        = RECEIVE;
        end
      end
      RECEIVE: begin
        if (w_sample_edge) begin
          w_shift_nxt[w_idx] = w_data;
          if (r_bit_cnt == 3'(BITS_PER_FRAME - 1)) begin
            w_valid_nxt   = 1'b1;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else if (w_timeout) begin
          w_error_nxt   = 1'b1;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_bit_cnt_nxt = 3'd0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_valid <= w_valid_nxt;
      r_rx_error <= w_error_nxt;
      if (w_valid_nxt) r_rx_data <= w_shift_nxt;
    end
  end

  // Saturating idle counter, only live while a frame is open.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != RECEIVE) || w_any_edge) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_MAX) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_error = r_rx_error;
  assign o_busy     = (r_state == RECEIVE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: three instances (mode 0 LSB-first, CPOL=1, MSB-first)
// share one scaled-down SPI stream so every frame is checked in all three configurations.
module tb_spi_slave_rx;

  localparam int MAIN = 160;
  localparam int SPI  = 10;
  localparam int SYNC = 2;
  localparam int T    = 2 * MAIN / SPI;
  localparam int HALF = MAIN / SPI / 2;
  localparam int N    = 7;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic sclk_n;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, e0, e1, e2, b0, b1, b2;

  assign sclk_n = ~sclk;

  spi_slave_rx #(.CPOL(1'b0), .MSB_FIRST(1'b0), .MAIN_CLOCK_FREQ(MAIN),
                 .SPI_CLOCK_FREQ(SPI), .SYNC_STAGES(SYNC)) u0 (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sclk), .i_spi_mosi(mosi),
    .o_rx_data(d0), .o_rx_valid(v0), .o_rx_error(e0), .o_busy(b0));

  spi_slave_rx #(.CPOL(1'b1), .MSB_FIRST(1'b0), .MAIN_CLOCK_FREQ(MAIN),
                 .SPI_CLOCK_FREQ(SPI), .SYNC_STAGES(SYNC)) u1 (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sclk_n), .i_spi_mosi(mosi),
    .o_rx_data(d1), .o_rx_valid(v1), .o_rx_error(e1), .o_busy(b1));

  spi_slave_rx #(.CPOL(1'b0), .MSB_FIRST(1'b1), .MAIN_CLOCK_FREQ(MAIN),
                 .SPI_CLOCK_FREQ(SPI), .SYNC_STAGES(SYNC)) u2 (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sclk), .i_spi_mosi(mosi),
    .o_rx_data(d2), .o_rx_valid(v2), .o_rx_error(e2), .o_busy(b2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q0[$], q1[$], q2[$];
  int n_err0 = 0, n_err1 = 0, n_err2 = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, last_rise_cyc = 0, last_edge_cyc = 0;
  int overlap = 0, wide = 0;
  logic pv0 = 1'b0, pe0 = 1'b0;
  int n_cmp = 0, n_bad = 0;

  always @(negedge clk) begin
    if (v0) begin q0.push_back(d0); last_valid_cyc = cyc; end
    if (v1) q1.push_back(d1);
    if (v2) q2.push_back(d2);
    if (e0) begin n_err0++; last_err_cyc = cyc; end
    if (e1) n_err1++;
    if (e2) n_err2++;
    if ((v0 && e0) || (v1 && e1) || (v2 && e2)) overlap++;
    if ((v0 && pv0) || (e0 && pe0)) wide++;
    pv0 = v0;
    pe0 = e0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mode-0 master behaviour: data set, half period, rising (sample) edge, half period, falling.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      last_edge_cyc = cyc;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      last_edge_cyc = cyc;
    end
  endtask

  function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  vec_t vecs[N];
  logic [7:0] old_data;
  int err_before, dt;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[2] = '{8'hC3, 8'hC3, 8'hC3};
    vecs[3] = '{8'h81, 8'h81, 8'h81};
    vecs[4] = '{8'h80, 8'h80, 8'h01};
    vecs[5] = '{8'h12, 8'h12, 8'h48};
    vecs[6] = '{8'hB4, 8'hB4, 8'h2D};

    // Reset values, then a long quiet period with spi_clk parked at CPOL.
    repeat (3) @(negedge clk);
    check("reset_data", 32'(d0), 32'h00);
    check("reset_valid", 32'(v0), 32'd0);
    check("reset_error", 32'(e0), 32'd0);
    check("reset_busy", 32'(b0), 32'd0);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("quiet_valids", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    check("quiet_errors", 32'(n_err0 + n_err1 + n_err2), 32'd0);
    check("quiet_busy", 32'({b0, b1, b2}), 32'd0);

    // Table frames sent back-to-back, no gap between bytes.
    for (int i = 0; i < N; i++) send_bits(vecs[i].tx, 8);
    repeat (10) @(negedge clk);
    check("b2b_count0", 32'(q0.size()), 32'(N));
    check("b2b_count1", 32'(q1.size()), 32'(N));
    check("b2b_count2", 32'(q2.size()), 32'(N));
    for (int i = 0; i < N; i++) begin
      check($sformatf("lsb_data[%0d]", i), 32'(qget(q0, i)), 32'(vecs[i].exp_lsb));
      check($sformatf("cpol1_data[%0d]", i), 32'(qget(q1, i)), 32'(vecs[i].exp_lsb));
      check($sformatf("msb_data[%0d]", i), 32'(qget(q2, i)), 32'(vecs[i].exp_msb));
    end
    check("b2b_errors", 32'(n_err0 + n_err1 + n_err2), 32'd0);
    check("valid_latency", 32'(last_valid_cyc - last_rise_cyc), 32'(SYNC + 2));
    check("idle_busy", 32'(b0), 32'd0);
    check("held_data", 32'(d0), 32'(vecs[N-1].exp_lsb));

    // Partial frame of four ones, then silence until the timeout fires.
    q0.delete(); q1.delete(); q2.delete();
    old_data = vecs[N-1].exp_lsb;
    err_before = n_err0;
    send_bits(8'hFF, 4);
    check("partial_busy", 32'(b0), 32'd1);
    for (int k = 0; k < T + 40 && n_err0 == err_before; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("timeout_err0", 32'(n_err0 - err_before), 32'd1);
    check("timeout_err1", 32'(n_err1), 32'd1);
    check("timeout_err2", 32'(n_err2), 32'd1);
    dt = last_err_cyc - last_edge_cyc;
    // The error may trail the silence by the synchroniser and register pipeline.
    check("timeout_window", 32'((dt >= T) && (dt <= T + SYNC + 3)), 32'd1);
    check("timeout_data_kept", 32'(d0), 32'(old_data));
    check("timeout_no_valid", 32'(q0.size()), 32'd0);
    check("timeout_busy", 32'(b0), 32'd0);
    send_bits(8'h5A, 8);
    repeat (10) @(negedge clk);
    check("after_tmo_lsb", 32'(qget(q0, 0)), 32'h5A);
    check("after_tmo_msb", 32'(qget(q2, 0)), 32'h5A);

    // Reset mid-frame after three bits of 0x77, then a clean 0x12.
    q0.delete(); q1.delete(); q2.delete();
    err_before = n_err0 + n_err1 + n_err2;
    send_bits(8'h77, 3);
    check("mid_busy", 32'(b0), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(d0), 32'h00);
    check("rst_busy", 32'({b0, b1, b2}), 32'd0);
    check("rst_pulses", 32'({v0, e0, v2, e2}), 32'd0);
    rst = 1'b0;
    repeat (3 * T) @(negedge clk);
    check("rst_no_valid", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    check("rst_no_error", 32'(n_err0 + n_err1 + n_err2), 32'(err_before));
    send_bits(8'h12, 8);
    repeat (10) @(negedge clk);
    check("post_rst_lsb", 32'(qget(q0, 0)), 32'h12);
    check("post_rst_cpol1", 32'(qget(q1, 0)), 32'h12);
    check("post_rst_msb", 32'(qget(q2, 0)), 32'h48);
    check("post_rst_count", 32'(q0.size()), 32'd1);

    check("valid_error_overlap", 32'(overlap), 32'd0);
    check("pulse_width", 32'(wide), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
